// File: rtl/motor_ctrl_pkg.sv
// Shared motor-control definitions: controller state encoding and default loop constants.
package motor_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StCompute,
        StApply,
        StFault
    } ctrl_state_t;

    localparam int unsigned DefStepShift   = 4;
    localparam int unsigned DefMaxStep     = 64;
    localparam int unsigned DefStallCycles = 2_000_000;

endpackage

// File: rtl/speed_loop_ctrl_if.sv
// Control/status bundle between the register block / frequency counter and the speed loop.
interface speed_loop_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  enable;
    logic [DATA_WIDTH-1:0] target_speed;
    logic [DATA_WIDTH-1:0] period;
    logic [DATA_WIDTH-1:0] speed;
    logic                  speed_valid;
    logic [DATA_WIDTH-1:0] duty;
    logic                  duty_update;
    logic                  fault;
    logic                  busy;

    modport master (
        output enable, target_speed, period, speed, speed_valid,
        input  duty, duty_update, fault, busy
    );

    modport slave (
        input  enable, target_speed, period, speed, speed_valid,
        output duty, duty_update, fault, busy
    );
endinterface

// File: rtl/ctrl_step_calc.sv
// Combinational duty step: shift error, saturate to +/-MAX_STEP, force a minimum step of one
// for small non-zero errors, then add to duty and clamp the result to [0, period].
module ctrl_step_calc #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STEP_SHIFT = 4,
    parameter int unsigned MAX_STEP   = 64
) (
    input  logic signed [DATA_WIDTH:0]   error_i,
    input  logic        [DATA_WIDTH-1:0] duty_i,
    input  logic        [DATA_WIDTH-1:0] period_i,
    output logic        [DATA_WIDTH-1:0] new_duty_o
);
    localparam logic signed [DATA_WIDTH:0] MaxPos = signed'((DATA_WIDTH + 1)'(MAX_STEP));
    localparam logic signed [DATA_WIDTH:0] MaxNeg = -MaxPos;
    localparam logic signed [DATA_WIDTH:0] One    = signed'((DATA_WIDTH + 1)'(1));
    localparam logic signed [DATA_WIDTH:0] NegOne = -One;

    logic signed [DATA_WIDTH:0]   raw;
    logic signed [DATA_WIDTH:0]   step;
    logic signed [DATA_WIDTH+1:0] sum;

    assign raw = error_i >>> STEP_SHIFT;

    always_comb begin
        step = raw;
        if (raw > MaxPos) begin
            step = MaxPos;
        end else if (raw < MaxNeg) begin
            step = MaxNeg;
        end
        // Small errors would otherwise never move the duty.
        if ((error_i != '0) && (raw == '0)) begin
            step = error_i[DATA_WIDTH] ? NegOne : One;
        end
    end

    assign sum = signed'({2'b00, duty_i}) + signed'({step[DATA_WIDTH], step});

    always_comb begin
        new_duty_o = sum[DATA_WIDTH-1:0];
        if (sum < 0) begin
            new_duty_o = '0;
        end else if (sum > signed'({2'b00, period_i})) begin
            new_duty_o = period_i;
        end
    end
endmodule

// File: rtl/speed_loop_ctrl.sv
// Closed-loop speed controller driving the PWM duty word.
// Define SPEED_LOOP_STALL_DET_EN to build the stall detector (FAULT state, fault output).
module speed_loop_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STEP_SHIFT   = DefStepShift,
    parameter int unsigned MAX_STEP     = DefMaxStep,
    parameter int unsigned STALL_CYCLES = DefStallCycles
) (
    input  logic              clk,
    input  logic              rst,
    speed_loop_ctrl_if.slave  ctrl_io
);
    ctrl_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] duty_q, duty_d;
    logic [DATA_WIDTH-1:0] speed_q, speed_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;
    logic                  upd_q, upd_d;
    logic                  fault_q, fault_d;
    logic                  busy_q, busy_d;

    logic signed [DATA_WIDTH:0] error;
    logic [DATA_WIDTH-1:0]      new_duty;
    logic [DATA_WIDTH-1:0]      duty_clamped;

`ifdef SPEED_LOOP_STALL_DET_EN
    localparam int unsigned CntW = $clog2(STALL_CYCLES + 1);
    logic [CntW-1:0] stall_q, stall_d;
`else
    logic unused_stall_cfg;
    assign unused_stall_cfg = ^STALL_CYCLES;
`endif

    assign error = signed'({1'b0, target_q}) - signed'({1'b0, speed_q});

    ctrl_step_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP_SHIFT (STEP_SHIFT),
        .MAX_STEP   (MAX_STEP)
    ) u_step_calc (
        .error_i    (error),
        .duty_i     (duty_q),
        .period_i   (ctrl_io.period),
        .new_duty_o (new_duty)
    );

    // Period may shrink under a running duty; pull duty down silently.
    assign duty_clamped = (duty_q > ctrl_io.period) ? ctrl_io.period : duty_q;

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        speed_d  = speed_q;
        target_d = target_q;
        upd_d    = 1'b0;
        fault_d  = fault_q;
`ifdef SPEED_LOOP_STALL_DET_EN
        stall_d  = stall_q;
`endif
        if (!ctrl_io.enable) begin
            state_d = StIdle;
            duty_d  = '0;
            fault_d = 1'b0;
`ifdef SPEED_LOOP_STALL_DET_EN
            stall_d = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    duty_d  = '0;
                    state_d = StWait;
                end
                StWait: begin
                    if (ctrl_io.speed_valid) begin
                        speed_d  = ctrl_io.speed;
                        target_d = ctrl_io.target_speed;
                        duty_d   = duty_clamped;
                        state_d  = StCompute;
`ifdef SPEED_LOOP_STALL_DET_EN
                        stall_d  = '0;
                    end else if (stall_q == CntW'(STALL_CYCLES)) begin
                        state_d = StFault;
                        duty_d  = '0;
                        fault_d = 1'b1;
                        stall_d = '0;
                    end else begin
                        duty_d = duty_clamped;
                        if (duty_q != '0) begin
                            stall_d = stall_q + CntW'(1);
                        end
`else
                    end else begin
                        duty_d = duty_clamped;
`endif
                    end
                end
                StCompute: begin
                    duty_d  = new_duty;
                    upd_d   = (new_duty != duty_q);
                    state_d = StApply;
                end
                StApply: begin
                    duty_d  = duty_clamped;
                    state_d = StWait;
                end
                StFault: begin
                    duty_d = '0;
                end
                default: begin
                    duty_d  = '0;
                    state_d = StIdle;
                end
            endcase
        end
        busy_d = (state_d == StCompute) || (state_d == StApply);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            duty_q   <= '0;
            speed_q  <= '0;
            target_q <= '0;
            upd_q    <= 1'b0;
            fault_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SPEED_LOOP_STALL_DET_EN
            stall_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            speed_q  <= speed_d;
            target_q <= target_d;
            upd_q    <= upd_d;
            fault_q  <= fault_d;
            busy_q   <= busy_d;
`ifdef SPEED_LOOP_STALL_DET_EN
            stall_q  <= stall_d;
`endif
        end
    end

    assign ctrl_io.duty        = duty_q;
    assign ctrl_io.duty_update = upd_q;
    assign ctrl_io.fault       = fault_q;
    assign ctrl_io.busy        = busy_q;
endmodule

// File: tb/tb_speed_loop_ctrl.sv
// Directed bench for speed_loop_ctrl with a scoreboard of expected duty updates.
module tb_speed_loop_ctrl;
    localparam int unsigned Dw    = 32;
    localparam int          Shift = 4;
    localparam longint      MaxSt = 64;

    typedef struct {
        logic [Dw-1:0] duty;
        logic          upd;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [Dw-1:0] exp_duty;
    exp_t sb_q[$];

    speed_loop_ctrl_if #(.DATA_WIDTH(Dw)) bus ();

    speed_loop_ctrl #(
        .DATA_WIDTH   (Dw),
        .STEP_SHIFT   (4),
        .MAX_STEP     (64),
        .STALL_CYCLES (50)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_io (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [Dw-1:0] model(input logic [Dw-1:0] cur, input logic [Dw-1:0] tgt,
                                            input logic [Dw-1:0] spd, input logic [Dw-1:0] per);
        longint err;
        longint st;
        longint nd;
        err = longint'({32'b0, tgt}) - longint'({32'b0, spd});
        st  = err >>> Shift;
        if (st > MaxSt) st = MaxSt;
        if (st < -MaxSt) st = -MaxSt;
        if (err != 0 && st == 0) st = (err > 0) ? 1 : -1;
        nd = longint'({32'b0, cur}) + st;
        if (nd < 0) nd = 0;
        if (nd > longint'({32'b0, per})) nd = longint'({32'b0, per});
        return nd[Dw-1:0];
    endfunction

    task automatic chk(input string tag, input logic [Dw-1:0] obs, input logic [Dw-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [Dw-1:0] tgt, input logic [Dw-1:0] spd);
        exp_t e;
        logic [Dw-1:0] nd;
        nd = model(exp_duty, tgt, spd, bus.period);
        e.duty = nd;
        e.upd  = (nd != exp_duty);
        sb_q.push_back(e);
        exp_duty = nd;
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_duty"}, bus.duty, e.duty);
            chk({tag, "_upd"}, {31'b0, bus.duty_update}, {31'b0, e.upd});
        end
    endtask

    // Called on a negedge while the DUT is in WAIT; returns on the negedge it is back in WAIT.
    task automatic sample(input string tag, input logic [Dw-1:0] tgt, input logic [Dw-1:0] spd);
        bus.target_speed = tgt;
        bus.speed        = spd;
        bus.speed_valid  = 1'b1;
        push_exp(tgt, spd);
        @(negedge clk);
        bus.speed_valid = 1'b0;
        chk({tag, "_busy_c"}, {31'b0, bus.busy}, 1);
        @(negedge clk);
        pop_chk(tag);
        chk({tag, "_busy_a"}, {31'b0, bus.busy}, 1);
        @(negedge clk);
        chk({tag, "_upd_clr"}, {31'b0, bus.duty_update}, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_duty = '0;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.period = 1000;
        bus.target_speed = '0;
        bus.speed = '0;
        bus.speed_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_duty", bus.duty, 0);
        chk("rst_upd", {31'b0, bus.duty_update}, 0);
        chk("rst_fault", {31'b0, bus.fault}, 0);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        rst = 1'b0;
        bus.enable = 1'b1;
        @(negedge clk);
        chk("wait_busy", {31'b0, bus.busy}, 0);

        sample("first", 500, 100);
        sample("sat_neg", 100, 5000);
        for (int i = 0; i < 14; i++) sample("ramp", 10000, 0);
        sample("plus4", 164, 100);
        sample("min_step", 105, 100);
        chk("duty_901", bus.duty, 901);

        bus.period = 800;
        @(negedge clk);
        chk("per_clamp_duty", bus.duty, 800);
        chk("per_clamp_upd", {31'b0, bus.duty_update}, 0);
        exp_duty = 800;
        sample("zero_err", 100, 100);
        sample("at_period", 10000, 0);
        sample("neg_small", 100, 105);

        // Back-to-back strobes: only the first and the one at T+3 are taken.
        bus.target_speed = 0;
        bus.speed = 320;
        bus.speed_valid = 1'b1;
        push_exp(0, 320);
        @(negedge clk);
        bus.target_speed = 5000;
        bus.speed = 0;
        @(negedge clk);
        pop_chk("drop_first");
        @(negedge clk);
        bus.target_speed = 0;
        bus.speed = 160;
        push_exp(0, 160);
        @(negedge clk);
        bus.speed_valid = 1'b0;
        @(negedge clk);
        pop_chk("t3_accept");
        @(negedge clk);
        chk("t3_upd_clr", {31'b0, bus.duty_update}, 0);

        bus.enable = 1'b0;
        @(negedge clk);
        chk("dis_duty", bus.duty, 0);
        chk("dis_busy", {31'b0, bus.busy}, 0);
        exp_duty = 0;
        bus.enable = 1'b1;
        bus.period = 1000;
        @(negedge clk);
        sample("reen", 500, 100);
        bus.period = 0;
        @(negedge clk);
        chk("per0_duty", bus.duty, 0);
        chk("per0_upd", {31'b0, bus.duty_update}, 0);
        exp_duty = 0;
        bus.period = 1000;

        // Reset while in COMPUTE, then a strobe in the IDLE cycle after release.
        bus.target_speed = 500;
        bus.speed = 100;
        bus.speed_valid = 1'b1;
        @(negedge clk);
        bus.speed_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_duty", bus.duty, 0);
        chk("mid_rst_upd", {31'b0, bus.duty_update}, 0);
        chk("mid_rst_busy", {31'b0, bus.busy}, 0);
        chk("mid_rst_fault", {31'b0, bus.fault}, 0);
        rst = 1'b0;
        bus.speed_valid = 1'b1;
        @(negedge clk);
        bus.speed_valid = 1'b0;
        chk("idle_strobe_busy", {31'b0, bus.busy}, 0);
        @(negedge clk);
        chk("idle_strobe_duty", bus.duty, 0);
        chk("idle_strobe_upd", {31'b0, bus.duty_update}, 0);
        sample("post_rst", 500, 100);

        repeat (60) @(negedge clk);
`ifdef SPEED_LOOP_STALL_DET_EN
        chk("stall_fault", {31'b0, bus.fault}, 1);
        chk("stall_duty", bus.duty, 0);
        bus.enable = 1'b0;
        @(negedge clk);
        chk("stall_clr", {31'b0, bus.fault}, 0);
        bus.enable = 1'b1;
        @(negedge clk);
        exp_duty = 0;
        sample("after_fault", 500, 100);
`else
        chk("no_stall_fault", {31'b0, bus.fault}, 0);
        chk("no_stall_duty", bus.duty, 25);
`endif
        chk("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
